// File: rtl/cla_4bit_augmented_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_4bit_augmented_if
// Brief    : Operand/result bundle for the registered 4-bit CLA slice.
// Revision : 1.0
// ============================================================================
interface cla_4bit_augmented_if;
  logic       in_valid;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       c_in;
  logic       out_valid;
  logic [3:0] sum;
  logic       p;
  logic       g;

  modport master (
    output in_valid, in1, in2, c_in,
    input  out_valid, sum, p, g
  );

  modport slave (
    input  in_valid, in1, in2, c_in,
    output out_valid, sum, p, g
  );
endinterface
`default_nettype wire

// File: rtl/cla_4bit_augmented.sv
`default_nettype none
// ============================================================================
// Module   : cla_4bit_augmented
// Brief    : Registered 4-bit carry-lookahead slice emitting sum plus group P/G.
// Revision : 1.0
// ============================================================================
module cla_4bit_augmented (
  input  logic                        clk,
  input  logic                        rst,
  cla_4bit_augmented_if.slave         bus
);

  logic [3:0] w_pi;
  logic [3:0] w_gi;
  logic [3:0] w_c;
  logic [3:0] w_sum;
  logic       w_p;
  logic       w_g;

  logic [3:0] r_sum;
  logic       r_p;
  logic       r_g;
  logic       r_out_valid;

  assign w_pi = bus.in1 ^ bus.in2;
  assign w_gi = bus.in1 & bus.in2;

  // Every carry is a flat sum-of-products of the operand terms; no carry feeds another.
  assign w_c[0] = bus.c_in;
  assign w_c[1] = w_gi[0]
                | (w_pi[0] & bus.c_in);
  assign w_c[2] = w_gi[1]
                | (w_pi[1] & w_gi[0])
                | (w_pi[1] & w_pi[0] & bus.c_in);
  assign w_c[3] = w_gi[2]
                | (w_pi[2] & w_gi[1])
                | (w_pi[2] & w_pi[1] & w_gi[0])
                | (w_pi[2] & w_pi[1] & w_pi[0] & bus.c_in);

  assign w_sum = w_pi ^ w_c;

  assign w_p = &w_pi;
  assign w_g = w_gi[3]
             | (w_pi[3] & w_gi[2])
             | (w_pi[3] & w_pi[2] & w_gi[1])
             | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= 4'd0;
      r_p         <= 1'b0;
      r_g         <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_sum       <= w_sum;
      r_p         <= w_p;
      r_g         <= w_g;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.sum       = r_sum;
  assign bus.p         = r_p;
  assign bus.g         = r_g;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cla_4bit_augmented.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_4bit_augmented
// Brief    : Self-checking bench for cla_4bit_augmented against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_cla_4bit_augmented;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [3:0] exp_sum;
  logic       exp_p;
  logic       exp_g;
  logic       exp_valid;

  cla_4bit_augmented_if bus ();

  cla_4bit_augmented dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: ordinary integer addition; P means every bit pair differs, G means a+b overflows on its own.
  task automatic model_capture(input logic [3:0] a, input logic [3:0] b, input logic c);
    int t;
    t         = int'(a) + int'(b) + int'(c);
    exp_sum   = t[3:0];
    exp_p     = ((a ^ b) == 4'hF);
    exp_g     = ((int'(a) + int'(b)) >= 16);
    exp_valid = 1'b1;
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
    int t;
    @(negedge clk);
    bus.in_valid = v;
    bus.in1      = a;
    bus.in2      = b;
    bus.c_in     = c;
    @(posedge clk);
    #1;
    if (v) model_capture(a, b, c);
    else   exp_valid = 1'b0;
    check({tag, ".valid"}, 8'(bus.out_valid), 8'(exp_valid));
    check({tag, ".sum"},   8'(bus.sum),       8'(exp_sum));
    check({tag, ".p"},     8'(bus.p),         8'(exp_p));
    check({tag, ".g"},     8'(bus.g),         8'(exp_g));
    if (v) begin
      t = int'(a) + int'(b) + int'(c);
      check({tag, ".cout"}, 8'(bus.g | (bus.p & c)), 8'(t[4]));
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    exp_sum      = 4'd0;
    exp_p        = 1'b0;
    exp_g        = 1'b0;
    exp_valid    = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in1      = 4'd0;
    bus.in2      = 4'd0;
    bus.c_in     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 8'(bus.out_valid), 8'd0);
    check("rst.sum",   8'(bus.sum),       8'd0);
    check("rst.pg",    8'({bus.p, bus.g}), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load nonzero state, then reset asynchronously in the middle of a cycle.
    step("pre", 1'b1, 4'd15, 4'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async.valid", 8'(bus.out_valid), 8'd0);
    check("async.sum",   8'(bus.sum),       8'd0);
    check("async.p",     8'(bus.p),         8'd0);
    bus.in_valid = 1'b1;
    bus.in1      = 4'd9;
    bus.in2      = 4'd9;
    bus.c_in     = 1'b1;
    @(posedge clk);
    #1;
    check("rstwin.valid", 8'(bus.out_valid), 8'd0);
    check("rstwin.sum",   8'(bus.sum),       8'd0);
    check("rstwin.g",     8'(bus.g),         8'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_sum      = 4'd0;
    exp_p        = 1'b0;
    exp_g        = 1'b0;
    exp_valid    = 1'b0;

    step("add440", 1'b1, 4'd4, 4'd4, 1'b0);
    check("add440.lit", 8'(bus.sum), 8'd8);
    step("add321", 1'b1, 4'd3, 4'd2, 1'b1);
    check("add321.lit", 8'(bus.sum), 8'd6);
    step("gen", 1'b1, 4'd4, 4'd12, 1'b0);
    check("gen.lit", 8'({bus.sum, bus.p, bus.g}), 8'b0000_0_1);
    step("prop1", 1'b1, 4'd8, 4'd7, 1'b1);
    check("prop1.lit", 8'({bus.sum, bus.p, bus.g}), 8'b0000_1_0);
    step("prop0", 1'b1, 4'd8, 4'd7, 1'b0);
    check("prop0.lit", 8'({bus.sum, bus.p, bus.g}), 8'b1111_1_0);

    step("b2b0", 1'b1, 4'd1, 4'd0, 1'b1);
    check("b2b0.lit", 8'({bus.sum, bus.p, bus.g}), 8'b0010_0_0);
    step("b2b1", 1'b1, 4'd15, 4'd15, 1'b1);
    check("b2b1.lit", 8'({bus.sum, bus.p, bus.g}), 8'b1111_0_1);
    step("hold", 1'b0, 4'd5, 4'd6, 1'b0);
    check("hold.lit", 8'({bus.out_valid, bus.sum, bus.p, bus.g}), 8'b0_1111_0_1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("sweep", 1'b1, v[8:5], v[4:1], v[0]);
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      step("rand", r[0] | r[1], r[7:4], r[11:8], r[12]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cla_4bit_augmented.md
# cla_4bit_augmented

Registered 4-bit carry-lookahead adder slice with a one-cycle result pipeline. It produces the 4-bit sum plus group propagate (p) and group generate (g) instead of a carry-out. A parent lookahead carry unit uses p and g to build wider adders, for example 16-bit from four slices. The block is the leaf adder of the team's hierarchical CLA datapath.

## Interface
- No parameters; width fixed at 4 bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registers immediately.
- in_valid  input  1  qualifies in1/in2/c_in for capture on this rising edge.
- in1  input  4  operand A, unsigned.
- in2  input  4  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  registered; high for one cycle per accepted operand set.
- sum  output  4  registered (in1 + in2 + c_in) mod 16.
- p  output  1  registered group propagate.
- g  output  1  registered group generate.

## Operation
- Per-bit terms, combinational:
  - pi = in1[i] XOR in2[i]
  - gi = in1[i] AND in2[i]
- Lookahead carries, flattened two-level sum-of-products with no ripple chain:
  - c0 = c_in
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
- sum[i] = pi XOR ci.
- Group signals:
  - P = p3p2p1p0
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0
- P and G are independent of c_in.
- The block has no carry-out port. The parent derives carry-out as G | (P & c_in).
- Capture: on a rising clk edge with in_valid=1 and rst=0, sum/p/g take the combinational results and out_valid goes to 1.
- Hold: on a rising edge with in_valid=0, sum/p/g hold their previous values and out_valid goes to 0.
- No backpressure; every valid input produces exactly one out_valid pulse.
- Inputs with X/Z are not supported; behaviour is undefined.

## Timing
- Latency is 1 cycle: operands captured at edge N appear on sum/p/g at edge N, and are stable through the cycle before edge N+1.
- Throughput is one operation per cycle; back-to-back in_valid is supported.
- Reset values: sum=0, p=0, g=0, out_valid=0.
- Reset takes effect asynchronously on rst assertion, independent of clk.
- Reset mid-operation: a capture pending in the same cycle is discarded. The first capture occurs on the first rising edge after rst deasserts with in_valid=1.
- Simultaneous rst and in_valid at an edge: rst wins, and outputs stay at their reset values.
- Combinational depth is at most 4 gate levels from input to register D. No path may route through a ripple carry chain.

## Test plan
- Assert rst asynchronously mid-cycle -> all outputs go to 0 before the next edge. in_valid=1 during rst -> out_valid stays 0.
- Basic add without carry:
  - in1=4, in2=4, c_in=0 -> next cycle sum=8, p=0, g=0, out_valid=1.
  - in1=3, in2=2, c_in=1 -> sum=6, p=0, g=0.
- Generate path: in1=4, in2=12, c_in=0 -> sum=0, p=0, g=1 (parent carry-out=1).
- Propagate path: in1=8, in2=7, c_in=1 -> sum=0, p=1, g=0 (parent carry-out=1).
  - Same operands with c_in=0 -> sum=15, p=1, g=0.
- Back-to-back vectors, then in_valid=0:
  - Apply (1,0,1) then (15,15,1) on consecutive edges -> sum=2,p=0,g=0 followed by sum=15,p=0,g=1, out_valid high both cycles.
  - Next cycle with in_valid=0 -> out_valid=0 and sum/p/g held at 15/0/1.
- Exhaustive sweep: all 512 (in1,in2,c_in) combinations checked against the reference model. The model is sum=(in1+in2+c_in)&15, with p and g computed from the formulas above, and G|(P&c_in) required to equal bit 4 of in1+in2+c_in.
